issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Decode-stage issue scheduler: tracks every in-flight destination register across the EXE, MULT1-5, TL, cache and writeback stages.
- Stalls decode on RAW hazards whose producer cannot yet be bypassed, on WAW reordering, and on register-file write-port collisions.
- Publishes per-register ready state, so the bypass controller selects data only and no longer decides stalls.

Parameters:
NUM_REGS, 32, architectural registers; x0 never tracked
ALU_LAT, 1, issue-to-bypassable cycles for ALU ops
MUL_LAT, 5, issue-to-bypassable cycles for multiplies (MULT5 output)
LOAD_LAT, 2, minimum issue-to-cache-stage cycles for loads
CNT_W, 3, countdown width; must hold MUL_LAT

Ports:
clk_i  in  1  clock
rsn_i  in  1  synchronous active-low reset
dec_valid_i  in  1  decode holds a valid instruction
dec_class_i  in  2  0=ALU, 1=MUL, 2=LOAD, 3=STORE/other (no writeback slot)
dec_wr_en_i  in  1  instruction writes rd
dec_rd_addr_i  in  5  destination register
dec_use_a_i  in  1  rs1 read
dec_read_addr_a_i  in  5  rs1
dec_use_b_i  in  1  rs2 read
dec_read_addr_b_i  in  5  rs2
cache_hit_i  in  1  load in cache stage hit
cache_addr_i  in  5  rd of that load
write_en_i  in  1  writeback committing
write_addr_i  in  5  committed rd
stall_core_o  out  1  hold decode/fetch this cycle
stall_cause_o  out  2  0 none, 1 RAW, 2 WAW, 3 write-port
ready_mask_o  out  NUM_REGS  bit r = value of r bypassable or in regfile
stall_cnt_raw_o / stall_cnt_waw_o / stall_cnt_port_o  out  32 each  see Optional Feature

Behaviour:
- Reset: synchronous, active-low, sampled on the clk_i rising edge. Clears all entries and the port reservation vector; stall_core_o=0, stall_cause_o=0, ready_mask_o=all ones. Reset mid-operation discards all in-flight tracking.
- Per-register entry: busy, cnt[CNT_W-1:0], is_load, load_done.
- ready[r] = !busy | (cnt==0 & (!is_load | load_done)). Register 0 is always ready and never set busy.
- Issue accepted when dec_valid_i & !stall_core_o.
- On an accepted issue with dec_wr_en_i & rd!=0, rd is loaded with busy=1 and cnt = ALU_LAT / MUL_LAT / LOAD_LAT by class. is_load=(class==LOAD); load_done=0.
- Every cycle, each busy entry with cnt>0 decrements by 1 (saturates at 0).
- cache_hit_i with a busy is_load entry at cache_addr_i and cnt==0 sets load_done. A miss leaves the entry not ready indefinitely.
- write_en_i clears busy[write_addr_i]. If an issue sets the same register in the same cycle, the issue wins.
- RAW: dec_valid_i & dec_use_X_i & addrX!=0 & !ready[addrX].
- WAW: dec_wr_en_i & busy[rd] & remaining latency of rd (cnt; LOAD counts as not done) > new latency. Issuing ALU after a MUL to the same rd therefore stalls until the MUL cnt ≤ ALU_LAT.
- Write-port reservation: a (MUL_LAT+1)-bit vector shifts right each cycle. An accepted issue of class c sets bit LAT(c). Classes 3 and wr_en=0 reserve nothing.
- Port conflict: the target bit is already set after this cycle's shift.
- stall_core_o is combinational from current state plus decode inputs. stall_cause_o encodes the highest-priority active cause, priority RAW > WAW > port.
- No state changes for a stalled instruction; stalls add no latency beyond the hazard itself.
- ready_mask_o is combinational from state.

Optional Feature:
SB_PERF_CNT_EN
- Defined: three 32-bit wrapping counters increment once per cycle in which stall_core_o=1, keyed by stall_cause_o. All three reset to 0.
- Undefined: counters are not instantiated and the three ports are driven 0.

Test Plan:
- MUL x5 issues at cycle 0, ALU reads x5 at cycle 1 -> stall_core_o=1 with cause 1 for cycles 1-4. Issue occurs at cycle 5, when ready_mask_o[5]=1.
- LOAD x7, dependent ADD reads x7, cache_hit_i held 0 for 6 cycles then 1 with cache_addr_i=7 -> stall persists until the cycle after the hit, then clears.
- MUL x3 then immediately ALU writing x3 -> WAW cause 2 until the MUL cnt ≤ 1, then the ALU issues. After writeback, busy[3] reflects only the ALU.
- MUL at cycle 0, unrelated ALU issued at cycle 4 -> port conflict cause 3 for one cycle, ALU accepted at cycle 5.
- Writeback of x9 and issue of a new writer of x9 in the same cycle -> x9 stays busy with the new latency.
- Reset asserted mid-MUL, then a reader of the MUL rd issues -> no stall, ready_mask_o all ones. With SB_PERF_CNT_EN, counters return to 0.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Decode-stage issue scoreboard: per-register readiness, RAW/WAW/write-port stall generation.
// Optional stall-cause performance counters are enabled with SB_PERF_CNT_EN.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ALU_LAT  = 1,
  parameter int MUL_LAT  = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 3
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                dec_valid_i,
  input  logic [1:0]          dec_class_i,
  input  logic                dec_wr_en_i,
  input  logic [4:0]          dec_rd_addr_i,
  input  logic                dec_use_a_i,
  input  logic [4:0]          dec_read_addr_a_i,
  input  logic                dec_use_b_i,
  input  logic [4:0]          dec_read_addr_b_i,
  input  logic                cache_hit_i,
  input  logic [4:0]          cache_addr_i,
  input  logic                write_en_i,
  input  logic [4:0]          write_addr_i,
  output logic                stall_core_o,
  output logic [1:0]          stall_cause_o,
  output logic [NUM_REGS-1:0] ready_mask_o,
  output logic [31:0]         stall_cnt_raw_o,
  output logic [31:0]         stall_cnt_waw_o,
  output logic [31:0]         stall_cnt_port_o
);

  localparam int RES_W = MUL_LAT + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [NUM_REGS-1:0] busy_q, busy_d, is_load_q, is_load_d, done_q, done_d;
  cnt_t                cnt_q [NUM_REGS];
  cnt_t                cnt_d [NUM_REGS];
  logic [RES_W-1:0]    res_q, res_d, res_shift_s;
  logic [NUM_REGS-1:0] ready_s;
  cnt_t                new_lat_s;
  logic                writes_s, raw_s, waw_s, port_s, accept_s;

  function automatic cnt_t lat_of(input logic [1:0] cls);
    case (cls)
      2'd0:    lat_of = cnt_t'(ALU_LAT);
      2'd1:    lat_of = cnt_t'(MUL_LAT);
      2'd2:    lat_of = cnt_t'(LOAD_LAT);
      default: lat_of = {CNT_W{1'b0}};
    endcase
  endfunction

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ready_s[r] = !busy_q[r] | ((cnt_q[r] == {CNT_W{1'b0}}) & (!is_load_q[r] | done_q[r]));
    end
    ready_s[0] = 1'b1;
  end

  // Class 3 has no writeback slot, so it neither tracks rd nor reserves the port.
  always_comb begin
    new_lat_s   = lat_of(dec_class_i);
    writes_s    = dec_wr_en_i & (dec_class_i != 2'd3);
    res_shift_s = res_q >> 1;
    raw_s = dec_valid_i &
            ((dec_use_a_i & (dec_read_addr_a_i != 5'd0) & !ready_s[dec_read_addr_a_i]) |
             (dec_use_b_i & (dec_read_addr_b_i != 5'd0) & !ready_s[dec_read_addr_b_i]));
    waw_s = dec_valid_i & writes_s & busy_q[dec_rd_addr_i] &
            ((is_load_q[dec_rd_addr_i] & !done_q[dec_rd_addr_i]) |
             (cnt_q[dec_rd_addr_i] > new_lat_s));
    port_s = dec_valid_i & writes_s & res_shift_s[new_lat_s];
  end

  always_comb begin
    stall_core_o = rsn_i & (raw_s | waw_s | port_s);
    if (!rsn_i) begin
      stall_cause_o = 2'd0;
    end else if (raw_s) begin
      stall_cause_o = 2'd1;
    end else if (waw_s) begin
      stall_cause_o = 2'd2;
    end else if (port_s) begin
      stall_cause_o = 2'd3;
    end else begin
      stall_cause_o = 2'd0;
    end
    ready_mask_o = ready_s | {NUM_REGS{!rsn_i}};
    accept_s     = dec_valid_i & !stall_core_o;
  end

  // A fresh entry is loaded already decremented so that an ALU result is bypassable next cycle.
  always_comb begin
    if (accept_s & writes_s) begin
      res_d = res_shift_s | (RES_W'(1) << new_lat_s);
    end else begin
      res_d = res_shift_s;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d[r]    = busy_q[r];
      is_load_d[r] = is_load_q[r];
      done_d[r]    = done_q[r];
      if (cnt_q[r] != {CNT_W{1'b0}}) begin
        cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
      if (cache_hit_i & (cache_addr_i == 5'(r)) & busy_q[r] & is_load_q[r] &
          (cnt_q[r] == {CNT_W{1'b0}})) begin
        done_d[r] = 1'b1;
      end else begin
        done_d[r] = done_q[r];
      end
      if (accept_s & writes_s & (dec_rd_addr_i == 5'(r)) & (dec_rd_addr_i != 5'd0)) begin
        busy_d[r]    = 1'b1;
        cnt_d[r]     = new_lat_s - cnt_t'(1);
        is_load_d[r] = (dec_class_i == 2'd2);
        done_d[r]    = 1'b0;
      end else if (write_en_i & (write_addr_i == 5'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      busy_q    <= {NUM_REGS{1'b0}};
      is_load_q <= {NUM_REGS{1'b0}};
      done_q    <= {NUM_REGS{1'b0}};
      res_q     <= {RES_W{1'b0}};
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= {CNT_W{1'b0}};
      end
    end else begin
      busy_q    <= busy_d;
      is_load_q <= is_load_d;
      done_q    <= done_d;
      res_q     <= res_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef SB_PERF_CNT_EN
  logic [31:0] cnt_raw_q, cnt_waw_q, cnt_port_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      cnt_raw_q  <= 32'd0;
      cnt_waw_q  <= 32'd0;
      cnt_port_q <= 32'd0;
    end else if (stall_core_o) begin
      case (stall_cause_o)
        2'd1:    cnt_raw_q  <= cnt_raw_q + 32'd1;
        2'd2:    cnt_waw_q  <= cnt_waw_q + 32'd1;
        2'd3:    cnt_port_q <= cnt_port_q + 32'd1;
        default: cnt_raw_q  <= cnt_raw_q;
      endcase
    end else begin
      cnt_raw_q <= cnt_raw_q;
    end
  end

  assign stall_cnt_raw_o  = cnt_raw_q;
  assign stall_cnt_waw_o  = cnt_waw_q;
  assign stall_cnt_port_o = cnt_port_q;
`else
  assign stall_cnt_raw_o  = 32'd0;
  assign stall_cnt_waw_o  = 32'd0;
  assign stall_cnt_port_o = 32'd0;
`endif

endmodule
